// File: rtl/intra_mode_decision_pkg.sv
// Shared types and constants for the macroblock intra mode decision.
// States, decision codes and 16x16 mode numbering.
package intra_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic I4X4   = 1'b1;
  localparam logic I16X16 = 1'b0;

  localparam logic [1:0] VERT  = 2'd0;
  localparam logic [1:0] HORZ  = 2'd1;
  localparam logic [1:0] DC    = 2'd2;
  localparam logic [1:0] PLANE = 2'd3;

endpackage

// File: rtl/intra_mode_decision_min_tracker.sv
// Running minimum of streamed 16x16 candidate costs with mode index.
// Strict compare: on equal cost the earlier candidate is kept.
module intra_min_tracker
  import intra_pkg::*;
#(
  parameter int COST_W = 12,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [COST_W-1:0] cost,
  input  logic [MODE_W-1:0] mode,
  output logic [COST_W-1:0] best_cost,
  output logic [MODE_W-1:0] best_mode
);

  logic [COST_W-1:0] r_cost;
  logic [MODE_W-1:0] r_mode;

  // keep the cheapest candidate seen since the last clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cost <= '1;
      r_mode <= '0;
    end else if (clear) begin
      r_cost <= '1;
      r_mode <= '0;
    end else if (valid && (cost < r_cost)) begin
      r_cost <= cost;
      r_mode <= mode;
    end
  end

  assign best_cost = r_cost;
  assign best_mode = r_mode;

endmodule

// File: rtl/intra_mode_decision.sv
// Per-macroblock I4x4 vs I16x16 decision over streamed costs.
// Sums 4x4 costs, tracks the 16x16 minimum, hands off one result.
module intra_mode_decision
  import intra_pkg::*;
#(
  parameter int COST_W  = 12,
  parameter int NUM_SUB = 16,
  parameter int NUM_M16 = 4,
  parameter int MODE_W  = 2,
  parameter int SUM_W   = COST_W + $clog2(NUM_SUB),
  parameter logic [SUM_W-1:0] BIAS = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  output logic              in_ready,
  input  logic              cost4_valid,
  input  logic [COST_W-1:0] cost4,
  input  logic              cost16_valid,
  input  logic [COST_W-1:0] cost16,
  input  logic [MODE_W-1:0] cost16_mode,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              decision,
  output logic [MODE_W-1:0] best16_mode,
  output logic [COST_W-1:0] best16_cost,
  output logic [SUM_W-1:0]  sum4
);

  localparam int C4_W  = $clog2(NUM_SUB + 1);
  localparam int C16_W = $clog2(NUM_M16 + 1);
  localparam int LW    = SUM_W + 1;

  localparam logic [C4_W-1:0]  L_NSUB = C4_W'(NUM_SUB);
  localparam logic [C16_W-1:0] L_NM16 = C16_W'(NUM_M16);

  state_t r_state;
  state_t w_next;

  logic [C4_W-1:0]   r_cnt4;
  logic [C16_W-1:0]  r_cnt16;
  logic [SUM_W-1:0]  r_acc;

  logic              r_decision;
  logic [MODE_W-1:0] r_best_mode;
  logic [COST_W-1:0] r_best_cost;
  logic [SUM_W-1:0]  r_sum4;

  logic              w_start;
  logic              w_acc4;
  logic              w_acc16;
  logic              w_done;
  logic              w_update;
  logic [COST_W-1:0] w_trk_cost;
  logic [MODE_W-1:0] w_trk_mode;
  logic [LW-1:0]     w_lhs;
  logic [LW-1:0]     w_rhs;
  logic              w_i16;

  assign w_start  = (r_state == IDLE) && start && !flush;
  assign w_acc4   = (r_state == COLLECT) && cost4_valid
                  && (r_cnt4 < L_NSUB);
  assign w_acc16  = (r_state == COLLECT) && cost16_valid
                  && (r_cnt16 < L_NM16);
  assign w_done   = (r_cnt4 == L_NSUB) && (r_cnt16 == L_NM16);
  assign w_update = (r_state == DECIDE) && !flush;

  // one extra bit so sum plus bias can never wrap
  assign w_lhs = {1'b0, r_acc} + {1'b0, BIAS};
  assign w_rhs = LW'(w_trk_cost);
  assign w_i16 = w_lhs > w_rhs;

  intra_min_tracker #(
    .COST_W (COST_W),
    .MODE_W (MODE_W)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_start),
    .valid     (w_acc16),
    .cost      (cost16),
    .mode      (cost16_mode),
    .best_cost (w_trk_cost),
    .best_mode (w_trk_mode)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state; flush wins over start and the output handshake
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (start)     w_next = COLLECT;
        COLLECT: if (w_done)    w_next = DECIDE;
        DECIDE:                 w_next = HOLD;
        HOLD:    if (dec_ready) w_next = IDLE;
        default:                w_next = IDLE;
      endcase
    end
  end

  // sample counters and 4x4 accumulator, cleared on start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt4  <= '0;
      r_cnt16 <= '0;
      r_acc   <= '0;
    end else if (w_start) begin
      r_cnt4  <= '0;
      r_cnt16 <= '0;
      r_acc   <= '0;
    end else begin
      if (w_acc4) begin
        r_cnt4 <= r_cnt4 + C4_W'(1);
        r_acc  <= r_acc + SUM_W'(cost4);
      end
      if (w_acc16) begin
        r_cnt16 <= r_cnt16 + C16_W'(1);
      end
    end
  end

  // result registers load only in DECIDE and hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_decision  <= I16X16;
      r_best_mode <= '0;
      r_best_cost <= '1;
      r_sum4      <= '0;
    end else if (w_update) begin
      r_decision  <= w_i16 ? I16X16 : I4X4;
      r_best_mode <= w_trk_mode;
      r_best_cost <= w_trk_cost;
      r_sum4      <= r_acc;
    end
  end

  assign in_ready    = (r_state == COLLECT);
  assign dec_valid   = (r_state == HOLD);
  assign decision    = r_decision;
  assign best16_mode = r_best_mode;
  assign best16_cost = r_best_cost;
  assign sum4        = r_sum4;

endmodule

// File: tb/tb_intra_mode_decision.sv
// Directed bench for intra_mode_decision.
// Two instances share stimulus: default bias and bias 24.
module tb_intra_mode_decision;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic        cost4_valid;
  logic [11:0] cost4;
  logic        cost16_valid;
  logic [11:0] cost16;
  logic [1:0]  cost16_mode;
  logic        dec_ready;

  logic        in_ready_a, dec_valid_a, decision_a;
  logic [1:0]  mode_a;
  logic [11:0] cost_a;
  logic [15:0] sum_a;

  logic        in_ready_b, dec_valid_b, decision_b;
  logic [1:0]  mode_b;
  logic [11:0] cost_b;
  logic [15:0] sum_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  intra_mode_decision u_a (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .in_ready     (in_ready_a),
    .cost4_valid  (cost4_valid),
    .cost4        (cost4),
    .cost16_valid (cost16_valid),
    .cost16       (cost16),
    .cost16_mode  (cost16_mode),
    .dec_valid    (dec_valid_a),
    .dec_ready    (dec_ready),
    .decision     (decision_a),
    .best16_mode  (mode_a),
    .best16_cost  (cost_a),
    .sum4         (sum_a)
  );

  intra_mode_decision #(
    .BIAS (16'd24)
  ) u_b (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .in_ready     (in_ready_b),
    .cost4_valid  (cost4_valid),
    .cost4        (cost4),
    .cost16_valid (cost16_valid),
    .cost16       (cost16),
    .cost16_mode  (cost16_mode),
    .dec_valid    (dec_valid_b),
    .dec_ready    (dec_ready),
    .decision     (decision_b),
    .best16_mode  (mode_b),
    .best16_cost  (cost_b),
    .sum4         (sum_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [11:0] c4v,
                      input logic [11:0] m0,
                      input logic [11:0] m1,
                      input logic [11:0] m2,
                      input logic [11:0] m3);
    logic [11:0] c16 [4];
    c16 = '{m0, m1, m2, m3};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("in_ready_collect", 32'(in_ready_a), 1);
    for (int i = 0; i < 16; i++) begin
      cost4_valid = 1'b1;
      cost4       = c4v;
      if (i < 4) begin
        cost16_valid = 1'b1;
        cost16       = c16[i];
        cost16_mode  = 2'(i);
      end else begin
        cost16_valid = 1'b0;
      end
      tick();
    end
    cost4_valid  = 1'b0;
    cost16_valid = 1'b0;
    chk("lat_edge0", 32'(dec_valid_a), 0);
    tick();
    chk("lat_edge1", 32'(dec_valid_a), 0);
    tick();
    chk("lat_edge2", 32'(dec_valid_a), 1);
  endtask

  task automatic release_dec();
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("dec_valid_drop", 32'(dec_valid_a), 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    flush        = 1'b0;
    cost4_valid  = 1'b0;
    cost4        = '0;
    cost16_valid = 1'b0;
    cost16       = '0;
    cost16_mode  = '0;
    dec_ready    = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready_a), 0);
    chk("rst_dec_valid", 32'(dec_valid_a), 0);
    chk("rst_decision", 32'(decision_a), 0);
    chk("rst_mode", 32'(mode_a), 0);
    chk("rst_cost", 32'(cost_a), 32'hFFF);
    chk("rst_sum", 32'(sum_a), 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready_a), 0);

    // basic: sum 160 vs best 150 at mode 1 (earlier of two 150s)
    feed(12'd10, 12'd200, 12'd150, 12'd150, 12'd300);
    chk("t1_mode", 32'(mode_a), 1);
    chk("t1_cost", 32'(cost_a), 150);
    chk("t1_sum", 32'(sum_a), 160);
    chk("t1_dec", 32'(decision_a), 0);

    // backpressure with stray cost4 and start in HOLD
    for (int k = 0; k < 5; k++) begin
      cost4_valid = 1'b1;
      cost4       = 12'd7;
      start       = (k == 2);
      tick();
      chk("bp_valid", 32'(dec_valid_a), 1);
      chk("bp_sum", 32'(sum_a), 160);
      chk("bp_dec", 32'(decision_a), 0);
      chk("bp_in_ready", 32'(in_ready_a), 0);
    end
    cost4_valid = 1'b0;
    start       = 1'b0;
    chk("bp_mode", 32'(mode_a), 1);
    chk("bp_cost", 32'(cost_a), 150);

    // handshake with simultaneous start: start must be ignored
    dec_ready = 1'b1;
    start     = 1'b1;
    tick();
    dec_ready = 1'b0;
    start     = 1'b0;
    chk("hs_dec_valid", 32'(dec_valid_a), 0);
    tick();
    chk("hs_start_ignored", 32'(in_ready_a), 0);

    // tie: 160 vs 160 -> I4x4; bias 24 instance -> I16x16
    feed(12'd10, 12'd300, 12'd400, 12'd160, 12'd500);
    chk("tie_dec", 32'(decision_a), 1);
    chk("tie_mode", 32'(mode_a), 2);
    chk("tie_cost", 32'(cost_a), 160);
    chk("tie_sum", 32'(sum_a), 160);
    chk("tie_dec_b", 32'(decision_b), 0);
    release_dec();

    // bias: sum 144, best 160; 168 > 160 only with bias
    feed(12'd9, 12'd160, 12'd170, 12'd180, 12'd190);
    chk("bias_dec_a", 32'(decision_a), 1);
    chk("bias_dec_b", 32'(decision_b), 0);
    chk("bias_sum_b", 32'(sum_b), 144);
    chk("bias_mode_b", 32'(mode_b), 0);
    chk("bias_cost_b", 32'(cost_b), 160);
    release_dec();

    // overflow: sixteen max costs, all-equal 16x16 costs
    feed(12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095);
    chk("ovf_sum", 32'(sum_a), 65520);
    chk("ovf_dec", 32'(decision_a), 0);
    chk("ovf_mode", 32'(mode_a), 0);
    chk("ovf_cost", 32'(cost_a), 4095);
    chk("ovf_sum_b", 32'(sum_b), 65520);
    release_dec();

    // abort after 7 cost4 samples with two very cheap 16x16 costs
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cost4_valid  = 1'b1;
      cost4        = 12'd50;
      cost16_valid = (i < 2);
      cost16       = 12'd5;
      cost16_mode  = 2'(i);
      tick();
    end
    cost4_valid  = 1'b0;
    cost16_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("abort_in_ready", 32'(in_ready_a), 0);
    chk("abort_dec_valid", 32'(dec_valid_a), 0);
    chk("abort_sum_kept", 32'(sum_a), 65520);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_valid", 32'(dec_valid_a), 0);
    end
    feed(12'd20, 12'd400, 12'd350, 12'd330, 12'd360);
    chk("fresh_sum", 32'(sum_a), 320);
    chk("fresh_mode", 32'(mode_a), 2);
    chk("fresh_cost", 32'(cost_a), 330);
    chk("fresh_dec", 32'(decision_a), 1);
    release_dec();

    // async reset mid-COLLECT, checked between clock edges
    start = 1'b1;
    tick();
    start       = 1'b0;
    cost4_valid = 1'b1;
    cost4       = 12'd3;
    tick();
    tick();
    chk("pre_rst_in_ready", 32'(in_ready_a), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready_a), 0);
    chk("arst_dec_valid", 32'(dec_valid_a), 0);
    chk("arst_decision", 32'(decision_a), 0);
    chk("arst_mode", 32'(mode_a), 0);
    chk("arst_cost", 32'(cost_a), 32'hFFF);
    chk("arst_sum", 32'(sum_a), 0);
    cost4_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(in_ready_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
